// File: rtl/sprite_pkg.sv
// Shared glyph IDs, glyph geometry and note-code helpers for the sprite note overlay.
package sprite_pkg;

    localparam logic [4:0] GLYPH_NONE  = 5'd0;
    localparam logic [4:0] GLYPH_C     = 5'd1;
    localparam logic [4:0] GLYPH_SHARP = 5'd2;
    localparam logic [4:0] GLYPH_D     = 5'd3;
    localparam logic [4:0] GLYPH_E     = 5'd4;
    localparam logic [4:0] GLYPH_F     = 5'd5;
    localparam logic [4:0] GLYPH_G     = 5'd6;
    localparam logic [4:0] GLYPH_A     = 5'd7;
    localparam logic [4:0] GLYPH_B     = 5'd8;

    localparam int GLYPH_W = 64;
    localparam int GLYPH_H = 128;
    localparam int SHARP_H = 96;

    function automatic logic code_in_range(input logic [3:0] code);
        return (code >= 4'd1) && (code <= 4'd12);
    endfunction

    function automatic logic [4:0] base_glyph(input logic [3:0] code);
        case (code)
            4'd1, 4'd2:   return GLYPH_C;
            4'd3, 4'd4:   return GLYPH_D;
            4'd5:         return GLYPH_E;
            4'd6, 4'd7:   return GLYPH_F;
            4'd8, 4'd9:   return GLYPH_G;
            4'd10, 4'd11: return GLYPH_A;
            4'd12:        return GLYPH_B;
            default:      return GLYPH_NONE;
        endcase
    endfunction

    function automatic logic is_sharp(input logic [3:0] code);
        case (code)
            4'd2, 4'd4, 4'd7, 4'd9, 4'd11: return 1'b1;
            default:                       return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/sprite_key_channel.sv
// One key channel: latches the note code, counts hold frames after release and
// snapshots the code at frame start. Optional blinking of decaying glyphs via SPRITE_BLINK_EN.
module sprite_key_channel
    import sprite_pkg::*;
#(
    parameter int HOLD_FRAMES = 8
`ifdef SPRITE_BLINK_EN
    , parameter int BLINK_FRAMES = 4
`endif
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       frame_start,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    output logic [3:0] snap
);

    localparam int                HOLD_W    = $clog2(HOLD_FRAMES + 1);
    localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(HOLD_FRAMES);

    logic              reload_s;
    logic [3:0]        code_r;
    logic [HOLD_W-1:0] hold_r;
    logic [3:0]        snap_r;
    logic [3:0]        snap_next_s;

    assign reload_s = key_valid && code_in_range(key_code);

    // Code latch and hold counter; a reload beats a same-cycle decay.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            code_r <= 4'd0;
            hold_r <= HOLD_W'(0);
        end else if (reload_s) begin
            code_r <= key_code;
            hold_r <= HOLD_INIT;
        end else if (frame_start && (hold_r != HOLD_W'(0))) begin
            hold_r <= hold_r - HOLD_W'(1);
            if (hold_r == HOLD_W'(1)) begin
                code_r <= 4'd0;
            end
        end
    end

`ifdef SPRITE_BLINK_EN
    localparam int BCNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [BCNT_W-1:0] bcnt_r;
    logic              phase_r;

    // Blink phase flips once every BLINK_FRAMES frame starts.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            bcnt_r  <= BCNT_W'(0);
            phase_r <= 1'b1;
        end else if (frame_start) begin
            if (int'(bcnt_r) == BLINK_FRAMES - 1) begin
                bcnt_r  <= BCNT_W'(0);
                phase_r <= ~phase_r;
            end else begin
                bcnt_r  <= bcnt_r + BCNT_W'(1);
            end
        end
    end

    // Decaying channels vanish during the off phase; held keys stay steady.
    always_comb begin
        snap_next_s = code_r;
        if (!reload_s && (hold_r != HOLD_W'(0)) && !phase_r) begin
            snap_next_s = 4'd0;
        end else begin
            snap_next_s = code_r;
        end
    end
`else
    assign snap_next_s = code_r;
`endif

    // Frame-start snapshot of the pre-update code so drawing never tears.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            snap_r <= 4'd0;
        end else if (frame_start) begin
            snap_r <= snap_next_s;
        end
    end

    assign snap = snap_r;

endmodule

// File: rtl/sprite_note_overlay.sv
// Multi-channel note glyph overlay: per-channel key state plus a 2-stage pixel pipeline
// producing sprite ID and glyph coordinates. Optional blinking via SPRITE_BLINK_EN.
module sprite_note_overlay
    import sprite_pkg::*;
#(
    parameter int         NUM_CH      = 4,
    parameter int         HOLD_FRAMES = 8,
    parameter int         SLOT_W_LOG2 = 7,
    parameter logic [9:0] X0          = 10'd0,
    parameter logic [9:0] Y0          = 10'd0
`ifdef SPRITE_BLINK_EN
    , parameter int       BLINK_FRAMES = 4
`endif
) (
    input  logic                Clk,
    input  logic                Reset_n,
    input  logic                frame_start,
    input  logic [NUM_CH-1:0]   key_valid,
    input  logic [4*NUM_CH-1:0] key_code,
    input  logic [1:0]          function_mode,
    input  logic [9:0]          DrawX,
    input  logic [9:0]          DrawY,
    output logic [4:0]          is_sprite,
    output logic [5:0]          sprite_x,
    output logic [6:0]          sprite_y
);

    localparam int SLOT_BITS = 10 - SLOT_W_LOG2;

    logic [4*NUM_CH-1:0]    snap_s;
    logic [1:0]             mode_r;
    logic [9:0]             lx_s;
    logic [9:0]             ly_s;
    logic                   in_range_s;
    logic [SLOT_W_LOG2-1:0] x_r;
    logic [9:0]             ly_r;
    logic [SLOT_BITS-1:0]   slot_r;
    logic                   in_range_r;
    logic [3:0]             code_sel_s;
    logic [4:0]             id_s;

    genvar c;
    generate
        for (c = 0; c < NUM_CH; c++) begin : g_ch
            sprite_key_channel #(
                .HOLD_FRAMES (HOLD_FRAMES)
`ifdef SPRITE_BLINK_EN
                , .BLINK_FRAMES (BLINK_FRAMES)
`endif
            ) u_ch (
                .Clk         (Clk),
                .Reset_n     (Reset_n),
                .frame_start (frame_start),
                .key_valid   (key_valid[c]),
                .key_code    (key_code[4*c +: 4]),
                .snap        (snap_s[4*c +: 4])
            );
        end
    endgenerate

    // UI mode is sampled with the key snapshots so a frame is drawn consistently.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            mode_r <= 2'd0;
        end else if (frame_start) begin
            mode_r <= function_mode;
        end
    end

    assign lx_s       = DrawX - X0;
    assign ly_s       = DrawY - Y0;
    assign in_range_s = (DrawX >= X0) && (DrawY >= Y0)
                        && (int'(lx_s[9:SLOT_W_LOG2]) < NUM_CH);

    // Stage 1: slot-relative coordinates and range flag.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            x_r        <= SLOT_W_LOG2'(0);
            ly_r       <= 10'd0;
            slot_r     <= SLOT_BITS'(0);
            in_range_r <= 1'b0;
        end else begin
            x_r        <= lx_s[SLOT_W_LOG2-1:0];
            ly_r       <= ly_s;
            slot_r     <= lx_s[9:SLOT_W_LOG2];
            in_range_r <= in_range_s;
        end
    end

    // Slot mux and glyph region decode.
    always_comb begin
        code_sel_s = 4'd0;
        for (int i = 0; i < NUM_CH; i++) begin
            code_sel_s = (int'(slot_r) == i) ? snap_s[4*i +: 4] : code_sel_s;
        end
        id_s = GLYPH_NONE;
        if (!in_range_r || (code_sel_s == 4'd0) || (mode_r == 2'd1) || (mode_r == 2'd2)) begin
            id_s = GLYPH_NONE;
        end else if ((int'(x_r) < GLYPH_W) && (int'(ly_r) < GLYPH_H)) begin
            id_s = base_glyph(code_sel_s);
        end else if ((int'(x_r) < 2 * GLYPH_W) && (int'(ly_r) < SHARP_H) && is_sharp(code_sel_s)) begin
            id_s = GLYPH_SHARP;
        end else begin
            id_s = GLYPH_NONE;
        end
    end

    // Stage 2: registered outputs; coordinates are zeroed when no glyph is shown.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            is_sprite <= 5'd0;
            sprite_x  <= 6'd0;
            sprite_y  <= 7'd0;
        end else begin
            is_sprite <= id_s;
            sprite_x  <= (id_s != GLYPH_NONE) ? x_r[5:0]  : 6'd0;
            sprite_y  <= (id_s != GLYPH_NONE) ? ly_r[6:0] : 7'd0;
        end
    end

endmodule

// File: tb/tb_sprite_note_overlay.sv
// Bench for sprite_note_overlay: directed vector table, multi-frame sequences and
// randomized traffic against a frame-level reference model.
module tb_sprite_note_overlay;

    localparam int NUM_CH = 4;
    localparam int HOLD   = 8;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        frame_start = 1'b0;
    logic [3:0]  key_valid = 4'd0;
    logic [15:0] key_code = 16'd0;
    logic [1:0]  function_mode = 2'd0;
    logic [9:0]  DrawX = 10'd0;
    logic [9:0]  DrawY = 10'd0;
    logic [4:0]  is_sprite;
    logic [5:0]  sprite_x;
    logic [6:0]  sprite_y;

    int total = 0;
    int bad   = 0;

    sprite_note_overlay dut (
        .Clk(Clk), .Reset_n(Reset_n), .frame_start(frame_start),
        .key_valid(key_valid), .key_code(key_code), .function_mode(function_mode),
        .DrawX(DrawX), .DrawY(DrawY),
        .is_sprite(is_sprite), .sprite_x(sprite_x), .sprite_y(sprite_y)
    );

    always #5 Clk = ~Clk;

    // Reference model state
    int code_m[NUM_CH];
    int hold_m[NUM_CH];
    int snap_m[NUM_CH];
    int mode_m;
    int p1x, p1y;
    int e_id, e_x, e_y;
    int base_tab[13] = '{0, 1, 1, 3, 3, 4, 5, 5, 6, 6, 7, 7, 8};

    function automatic void pix_model(input int dx, input int dy,
                                      output int id, output int ox, output int oy);
        int slot, x, code;
        id = 0; ox = 0; oy = 0;
        if (mode_m == 1 || mode_m == 2) return;
        slot = dx / 128;
        if (slot >= NUM_CH) return;
        code = snap_m[slot];
        if (code == 0) return;
        x = dx % 128;
        if (x < 64 && dy < 128)
            id = base_tab[code];
        else if (x >= 64 && dy < 96 && (code == 2 || code == 4 || code == 7 || code == 9 || code == 11))
            id = 2;
        if (id != 0) begin
            ox = x % 64;
            oy = dy % 128;
        end
    endfunction

    task automatic tick();
        int nid, nx, ny, kc;
        pix_model(p1x, p1y, nid, nx, ny);
        p1x = DrawX;
        p1y = DrawY;
        if (frame_start) begin
            for (int c = 0; c < NUM_CH; c++) snap_m[c] = code_m[c];
            mode_m = function_mode;
        end
        for (int c = 0; c < NUM_CH; c++) begin
            kc = key_code[4*c +: 4];
            if (key_valid[c] && kc >= 1 && kc <= 12) begin
                code_m[c] = kc;
                hold_m[c] = HOLD;
            end else if (frame_start && hold_m[c] > 0) begin
                hold_m[c]--;
                if (hold_m[c] == 0) code_m[c] = 0;
            end
        end
        @(posedge Clk);
        #1;
        e_id = nid; e_x = nx; e_y = ny;
    endtask

    task automatic check(input string name, input int id, input int x, input int y);
        total++;
        if ({is_sprite, sprite_x, sprite_y} !== {5'(id), 6'(x), 7'(y)}) begin
            bad++;
            $display("FAIL %s: got id=%0d x=%0d y=%0d, want id=%0d x=%0d y=%0d",
                     name, is_sprite, sprite_x, sprite_y, id, x, y);
        end
    endtask

    task automatic check_model(input string name);
        check(name, e_id, e_x, e_y);
    endtask

    task automatic do_reset();
        Reset_n = 1'b0;
        frame_start = 1'b0; key_valid = 4'd0; key_code = 16'd0;
        function_mode = 2'd0; DrawX = 10'd0; DrawY = 10'd0;
        for (int c = 0; c < NUM_CH; c++) begin
            code_m[c] = 0; hold_m[c] = 0; snap_m[c] = 0;
        end
        mode_m = 0; p1x = 0; p1y = 0; e_id = 0; e_x = 0; e_y = 0;
        #3;
        check("reset", 0, 0, 0);
        @(negedge Clk);
        Reset_n = 1'b1;
    endtask

    task automatic frame();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic show(input int dx, input int dy);
        DrawX = 10'(dx);
        DrawY = 10'(dy);
        tick();
        tick();
    endtask

    typedef struct {
        logic [3:0]  kv;
        logic [15:0] kc;
        logic [1:0]  mode;
        int dx, dy, id, x, y;
    } vec_t;

    vec_t vt[16];

    initial begin
        vt[0]  = '{4'b0001, 16'h0003, 2'd0,  10,  20, 3, 10,  20};
        vt[1]  = '{4'b0010, 16'h0090, 2'd0, 198,  50, 2,  6,  50};
        vt[2]  = '{4'b0010, 16'h0090, 2'd0, 198, 100, 0,  0,   0};
        vt[3]  = '{4'b0010, 16'h0090, 2'd0, 133, 100, 6,  5, 100};
        vt[4]  = '{4'b0001, 16'h000D, 2'd0,  10,  20, 0,  0,   0};
        vt[5]  = '{4'b1000, 16'hC000, 2'd0, 447, 127, 8, 63, 127};
        vt[6]  = '{4'b1000, 16'hC000, 2'd0, 448,  10, 0,  0,   0};
        vt[7]  = '{4'b0100, 16'h0200, 2'd0, 383,  95, 2, 63,  95};
        vt[8]  = '{4'b0100, 16'h0200, 2'd0, 320,  96, 0,  0,   0};
        vt[9]  = '{4'b0001, 16'h0001, 2'd1,   5,   6, 0,  0,   0};
        vt[10] = '{4'b0001, 16'h0001, 2'd2,   5,   6, 0,  0,   0};
        vt[11] = '{4'b0001, 16'h0001, 2'd3,   5,   6, 1,  5,   6};
        vt[12] = '{4'b0001, 16'h0005, 2'd0, 512,  10, 0,  0,   0};
        vt[13] = '{4'b0001, 16'h0005, 2'd0,  10, 128, 0,  0,   0};
        vt[14] = '{4'b0000, 16'h0006, 2'd0,  10,  20, 0,  0,   0};
        vt[15] = '{4'b1111, 16'hC531, 2'd0, 276,  30, 4, 20,  30};

        for (int i = 0; i < 16; i++) begin
            do_reset();
            key_valid = vt[i].kv;
            key_code = vt[i].kc;
            function_mode = vt[i].mode;
            tick();
            frame();
            show(vt[i].dx, vt[i].dy);
            check($sformatf("vec%0d", i), vt[i].id, vt[i].x, vt[i].y);
            check_model($sformatf("vec%0d_model", i));
        end

        // Hold decay after release: visible through the 8th frame start, gone at the 9th
        do_reset();
        key_valid = 4'b0001; key_code = 16'h0005;
        tick();
        key_valid = 4'b0000;
        for (int f = 1; f <= 9; f++) begin
            frame();
            show(10, 10);
            if (f <= 8) check($sformatf("decay_f%0d", f), 4, 10, 10);
            else        check($sformatf("decay_f%0d", f), 0, 0, 0);
        end

        // Blanking mode is frame-sticky
        do_reset();
        key_valid = 4'b0001; key_code = 16'h0001;
        tick();
        function_mode = 2'd1;
        frame();
        show(5, 6);
        check("mode_blank", 0, 0, 0);
        function_mode = 2'd0;
        show(5, 6);
        check("mode_midframe", 0, 0, 0);
        frame();
        show(5, 6);
        check("mode_next_frame", 1, 5, 6);

        // Reload coinciding with frame_start restarts the hold
        do_reset();
        key_valid = 4'b0001; key_code = 16'h0005;
        tick();
        key_valid = 4'b0000;
        repeat (7) frame();
        key_valid = 4'b0001;
        frame();
        key_valid = 4'b0000;
        repeat (7) frame();
        show(10, 10);
        check("reload_f7", 4, 10, 10);
        frame();
        show(10, 10);
        check("reload_f8", 4, 10, 10);
        frame();
        show(10, 10);
        check("reload_f9", 0, 0, 0);

        // Reset mid-frame blanks until the next frame start
        do_reset();
        key_valid = 4'b0001; key_code = 16'h0003;
        tick();
        frame();
        show(10, 20);
        check("pre_reset", 3, 10, 20);
        do_reset();
        key_valid = 4'b0001; key_code = 16'h0003;
        tick();
        show(10, 20);
        check("post_reset", 0, 0, 0);
        frame();
        show(10, 20);
        check("post_reset_frame", 3, 10, 20);

        // Randomized traffic, checked every cycle against the model
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 7) == 0) begin
                key_valid = 4'($urandom & $urandom);
                key_code = 16'($urandom);
            end
            if ($urandom_range(0, 31) == 0)
                function_mode = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'd0;
            frame_start = ($urandom_range(0, 15) == 0);
            DrawX = 10'($urandom_range(0, 600));
            DrawY = 10'($urandom_range(0, 140));
            tick();
            check_model("rand");
        end
        frame_start = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sprite_note_overlay.md
Name: sprite_note_overlay

Overview:
- Multi-channel, pipelined successor to the single-key sprite mapper.
- Shows up to NUM_CH highlighted note glyphs side by side: a base glyph per note, plus a sharp glyph for black keys.
- Each glyph persists HOLD_FRAMES frames after key release.
- Key state is snapshotted at frame start so a glyph never tears mid-frame. Output feeds the sprite ROM address / palette stage ahead of the VGA colour mux.

Parameters:
- NUM_CH, 4, number of simultaneous key channels / display slots
- HOLD_FRAMES, 8, frames a glyph persists after its key_valid drops (>=1)
- SLOT_W_LOG2, 7, log2 of slot width in pixels (slot = 128 px; must be >=7)
- X0, 10'd0, left pixel of slot 0
- Y0, 10'd0, top pixel of all slots
- BLINK_FRAMES, 4, frames per blink half-period (only with SPRITE_BLINK_EN)

Ports:
- Clk  in  1  pixel-domain clock
- Reset_n  in  1  asynchronous, active-low reset
- frame_start  in  1  one-cycle pulse at start of vertical blank
- key_valid  in  NUM_CH  per-channel key-held flag
- key_code  in  4*NUM_CH  per-channel note code 1..12 (channel c at [4c+3:4c])
- function_mode  in  2  UI mode; 1 or 2 blanks all glyphs
- DrawX  in  10  current pixel X
- DrawY  in  10  current pixel Y
- is_sprite  out  5  glyph ID; 0 = none
- sprite_x  out  6  column within glyph, 0..63
- sprite_y  out  7  row within glyph, 0..127

Behaviour:
- Reset (async, Reset_n=0): all channel codes, hold counters, snapshots, mode snapshot, pipeline registers and outputs go to 0.
- Channel update, every cycle:
  - If key_valid[c] and code in 1..12: code_r[c] <= key_code[c], hold[c] <= HOLD_FRAMES.
  - Codes 0 and 13..15 are treated as key_valid=0.
- Hold decay: on frame_start, a channel with no valid key this cycle and hold != 0 decrements hold. When hold reaches 0, code_r is cleared to 0 in the same cycle.
- Key reload and frame_start in the same cycle: reload wins (hold = HOLD_FRAMES).
- Snapshot: on frame_start, snap[c] <= code_r[c] and mode_s <= function_mode. Snapshot uses pre-update register values. Drawing reads only snap/mode_s.
- Pipeline, total latency exactly 2 cycles from DrawX/DrawY to outputs:
  - Stage 1 registers: lx = DrawX-X0, ly = DrawY-Y0, slot = lx>>SLOT_W_LOG2, and an in-range flag (DrawX>=X0, DrawY>=Y0, slot<NUM_CH).
  - Stage 2 registers is_sprite, sprite_x, sprite_y.
- Glyph map for code 1..12, base ID: 1,1,3,3,4,5,5,6,6,7,7,8.
- Sharp codes: 2,4,7,9,11. The sharp glyph ID is 2.
- Region rules (x = lx mod slot width, y = ly):
  - x<64 and y<128: base glyph.
  - 64<=x<128 and y<96 and code is sharp: ID 2.
  - Otherwise 0.
- Forced to 0 when: snap=0, out of range, or mode_s is 1 or 2.
- sprite_x = x[5:0], sprite_y = y[6:0] when is_sprite != 0; both are 0 otherwise.
- Reset mid-frame: outputs read 0 until the next frame_start loads snapshots.

Optional Feature:
- Macro SPRITE_BLINK_EN.
- Defined:
  - A blink phase register (reset 1) toggles every BLINK_FRAMES frame_starts.
  - A channel in decay (key not valid at snapshot time, hold != 0) snapshots as 0 while phase is 0.
  - Held keys never blink.
- Undefined: no phase logic; decaying glyphs are steady.

Decomposition:
- Package sprite_pkg:
  - glyph ID constants: GLYPH_NONE=0, GLYPH_SHARP=2, base IDs.
  - functions base_glyph(code) and is_sharp(code).
  - geometry constants: GLYPH_W=64, GLYPH_H=128, SHARP_H=96.
- Sub-module sprite_key_channel: latch, hold counter, snapshot, optional blink gating. Generated NUM_CH times.
- The top handles the pixel pipeline and slot muxing.

Test Plan:
- Reset, key_valid[0]=1 code 3, one frame_start, DrawX=10 DrawY=20 -> two cycles later is_sprite=3, sprite_x=10, sprite_y=20.
- Ch1 code 9, frame_start, DrawX=128+70, DrawY=50 -> is_sprite=2, sprite_x=6, sprite_y=50. At DrawY=100 same X -> 0.
- Ch0 code 5 held, then released; count frame_starts with HOLD_FRAMES=8 -> glyph 4 visible through snapshot after 7th decay frame_start; is_sprite=0 after 9th frame_start.
- function_mode=1 at frame_start while glyphs active -> all outputs 0 that frame. Mode changed to 0 mid-frame -> still 0 until next frame_start.
- key_code=13 with key_valid=1, and DrawX >= X0+NUM_CH*128 -> is_sprite=0.
- SPRITE_BLINK_EN, BLINK_FRAMES=2, released key: decaying glyph visible 2 frames, hidden 2, alternating until hold expires; a held key stays steady.
